msx_mouse_reader: RTL

//  MSX-side initiator for the MSX mouse strobe/nibble protocol on a joystick port.

---
 rtl/msx_mouse_pkg.sv | 20 ++
 rtl/msx_sync2.sv | 24 ++
 rtl/msx_mouse_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/msx_mouse_pkg.sv
// Shared types and constants for the MSX mouse strobe/nibble reader.
package msx_mouse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOGGLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Slot index of each nibble in the order the mouse sends them
    localparam int unsigned NIB_DX_HI = 0;
    localparam int unsigned NIB_DX_LO = 1;
    localparam int unsigned NIB_DY_HI = 2;
    localparam int unsigned NIB_DY_LO = 3;

    localparam int unsigned RETRY_MAX = 4;

endpackage

// File: rtl/msx_sync2.sv
// Two-flop synchroniser for asynchronous joystick pins; resets to all-ones
// because an idle, pulled-up port reads high.
module msx_sync2 #(
    parameter int unsigned W = 6
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/msx_mouse_reader.sv
// MSX-side initiator for the mouse strobe/nibble protocol: toggles the strobe
// four times per frame and assembles the sampled nibbles into dx/dy/buttons.
module msx_mouse_reader
    import msx_mouse_pkg::*;
#(
    parameter int unsigned SETTLE   = 64,
    parameter int unsigned POLL_DIV = 357955,
    parameter int unsigned RESP_TMO = 100000
) (
    input  logic              clk21m,
    input  logic              pSltRst_n,
    input  logic              enable,
    input  logic              poll_req,
    input  logic [5:0]        joy_in,
    output logic              strobe_o,
    output logic              busy,
    output logic signed [7:0] dx,
    output logic signed [7:0] dy,
    output logic [1:0]        btn,
    output logic              valid,
    output logic [7:0]        glitch_cnt
);

    localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned TMO_W  = $clog2(RESP_TMO + 1);

    logic [5:0]        joy_s;
    logic [3:0]        nib_s;
    state_t            state;
    logic [1:0]        nib;
    logic              phase;
    logic [2:0]        retry;
    logic [SET_W-1:0]  set_cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              aborted;
    logic [3:0]        smp_first;
    logic [3:0]        nib_q [4];
    logic [1:0]        btn_cap;

    logic poll_tick, tmo_done, start, in_sample, mismatch, accept;

    msx_sync2 #(.W(6)) u_sync (
        .clk_sys (clk21m),
        .reset_n (pSltRst_n),
        .d       (joy_in),
        .q       (joy_s)
    );

    assign nib_s     = joy_s[3:0];
    assign poll_tick = (POLL_DIV != 0) && enable && (poll_cnt == '0);
    assign tmo_done  = (tmo_cnt == TMO_W'(RESP_TMO));
    // After an abort the responder may sit mid-frame; wait out its timeout first
    assign start     = enable && (poll_tick || poll_req) && (!aborted || tmo_done);
    assign in_sample = (state == ST_SAMPLE) && enable;
    assign mismatch  = (nib_s != smp_first);
    assign accept    = in_sample && phase && (!mismatch || retry == 3'(RETRY_MAX));

    always_ff @(posedge clk21m or negedge pSltRst_n) begin
        if (!pSltRst_n) begin
            poll_cnt <= '0;
        end else if (!enable || poll_cnt == POLL_W'(POLL_DIV - 1)) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk21m) begin
        if (in_sample && !phase) smp_first <= nib_s;
        if (accept) begin
            nib_q[nib] <= ~nib_s;
            if (nib == 2'(NIB_DY_LO)) btn_cap <= ~joy_s[5:4];
        end
    end

    always_ff @(posedge clk21m or negedge pSltRst_n) begin
        if (!pSltRst_n) begin
            state      <= ST_IDLE;
            strobe_o   <= 1'b0;
            busy       <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            btn        <= '0;
            valid      <= 1'b0;
            glitch_cnt <= '0;
            nib        <= '0;
            phase      <= 1'b0;
            retry      <= '0;
            set_cnt    <= '0;
            tmo_cnt    <= '0;
            aborted    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!tmo_done) tmo_cnt <= tmo_cnt + 1'b1;
            if (state != ST_IDLE && !enable) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_TOGGLE;
                            nib     <= '0;
                            busy    <= 1'b1;
                            aborted <= 1'b0;
                        end
                    end
                    ST_TOGGLE: begin
                        strobe_o <= ~strobe_o;
                        set_cnt  <= SET_W'(SETTLE - 1);
                        tmo_cnt  <= '0;
                        phase    <= 1'b0;
                        retry    <= '0;
                        state    <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (set_cnt == '0) state <= ST_SAMPLE;
                        else               set_cnt <= set_cnt - 1'b1;
                    end
                    ST_SAMPLE: begin
                        if (!phase) begin
                            phase <= 1'b1;
                        end else begin
                            if (mismatch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 1'b1;
                            if (accept) begin
                                nib   <= nib + 1'b1;
                                state <= (nib == 2'(NIB_DY_LO)) ? ST_DONE : ST_TOGGLE;
                            end else begin
                                // Take a fresh pair so a one-cycle glitch costs one retry
                                retry <= retry + 1'b1;
                                phase <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        dx    <= {nib_q[NIB_DX_HI], nib_q[NIB_DX_LO]};
                        dy    <= {nib_q[NIB_DY_HI], nib_q[NIB_DY_LO]};
                        btn   <= btn_cap;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
